// File: rtl/arc4_pkg.sv
// arc4_pkg: shared PRGA state encoding, byte width and default printable-range bounds.
package arc4_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] CHK_LO_DEF = 8'h20;
    localparam logic [BYTE_W-1:0] CHK_HI_DEF = 8'h7E;

    typedef enum logic [2:0] {
        IDLE,
        RD_LEN,
        RD_SI,
        RD_SJ,
        WR_SWAP,
        RD_KS,
        WR_PT,
        DONE
    } prga_state_t;

    function automatic logic in_range(input logic [BYTE_W-1:0] b,
                                      input logic [BYTE_W-1:0] lo,
                                      input logic [BYTE_W-1:0] hi);
        return (b >= lo) && (b <= hi);
    endfunction

endpackage

// File: rtl/pt_range_chk.sv
// pt_range_chk: flags plaintext bytes outside [CHK_LO,CHK_HI]; sticky fail cleared on run start.
module pt_range_chk
    import arc4_pkg::*;
#(
    parameter logic [BYTE_W-1:0] CHK_LO = CHK_LO_DEF,
    parameter logic [BYTE_W-1:0] CHK_HI = CHK_HI_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_vld,
    input  logic [BYTE_W-1:0] i_byte,
    output logic              o_bad_c,
    output logic              o_fail
);

    logic r_fail;

    assign o_bad_c = i_vld && !in_range(i_byte, CHK_LO, CHK_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail <= 1'b0;
        end else if (i_clr) begin
            r_fail <= 1'b0;
        end else if (o_bad_c) begin
            r_fail <= 1'b1;
        end
    end

    assign o_fail = r_fail;

endmodule

// File: rtl/prga_check.sv
// prga_check: RC4 PRGA decrypt of ct RAM into pt RAM using S RAM, with printable-range verdict.
// Build option: define PRGA_EARLY_ABORT_EN to stop after writing the first out-of-range byte.
module prga_check
    import arc4_pkg::*;
#(
    parameter int unsigned       CT_AW  = 8,
    parameter logic [BYTE_W-1:0] CHK_LO = CHK_LO_DEF,
    parameter logic [BYTE_W-1:0] CHK_HI = CHK_HI_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    output logic              ok,
    output logic [BYTE_W-1:0] s_addr,
    input  logic [BYTE_W-1:0] s_rddata,
    output logic [BYTE_W-1:0] s_wrdata,
    output logic              s_wren,
    output logic [CT_AW-1:0]  ct_addr,
    input  logic [BYTE_W-1:0] ct_rddata,
    output logic [CT_AW-1:0]  pt_addr,
    output logic [BYTE_W-1:0] pt_wrdata,
    output logic              pt_wren
);

`ifdef PRGA_EARLY_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    prga_state_t       r_state, w_state_nxt;
    logic              r_ph, w_ph_nxt;
    logic [BYTE_W-1:0] r_i, w_i_nxt, r_j, w_j_nxt, r_k, w_k_nxt, r_len, w_len_nxt;
    logic [BYTE_W-1:0] r_si, w_si_nxt, r_sj, w_sj_nxt;
    logic              r_rdy, w_rdy_nxt, r_ok, w_ok_nxt;
    logic [BYTE_W-1:0] r_s_addr, w_s_addr_nxt, r_s_wrdata, w_s_wrdata_nxt;
    logic              r_s_wren, w_s_wren_nxt, r_pt_wren, w_pt_wren_nxt;
    logic [CT_AW-1:0]  r_ct_addr, w_ct_addr_nxt, r_pt_addr, w_pt_addr_nxt;
    logic [BYTE_W-1:0] r_pt_wrdata, w_pt_wrdata_nxt;
    logic [BYTE_W-1:0] w_i_inc;
    logic              w_clr, w_chk_vld, w_bad_c, w_fail, w_abort_c;

    // Only pt[1..L] are judged; pt[0] carries the length.
    assign w_chk_vld = (r_state == WR_PT) && (r_k != '0);
    assign w_abort_c = ABORT_EN && w_bad_c;
    assign w_i_inc   = r_i + BYTE_W'(1);

    pt_range_chk #(
        .CHK_LO (CHK_LO),
        .CHK_HI (CHK_HI)
    ) u_range (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_vld   (w_chk_vld),
        .i_byte  (r_pt_wrdata),
        .o_bad_c (w_bad_c),
        .o_fail  (w_fail)
    );

    // Each state names what is on the RAM buses or returning from them; reads land one cycle
    // after the address is driven, so address-wait cycles are the ph=0 half of a state.
    always_comb begin
        w_state_nxt     = r_state;
        w_ph_nxt        = r_ph;
        w_i_nxt         = r_i;
        w_j_nxt         = r_j;
        w_k_nxt         = r_k;
        w_len_nxt       = r_len;
        w_si_nxt        = r_si;
        w_sj_nxt        = r_sj;
        w_rdy_nxt       = r_rdy;
        w_ok_nxt        = r_ok;
        w_s_addr_nxt    = r_s_addr;
        w_s_wrdata_nxt  = r_s_wrdata;
        w_s_wren_nxt    = 1'b0;
        w_ct_addr_nxt   = r_ct_addr;
        w_pt_addr_nxt   = r_pt_addr;
        w_pt_wrdata_nxt = r_pt_wrdata;
        w_pt_wren_nxt   = 1'b0;
        w_clr           = 1'b0;

        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt = RD_LEN;
                    w_rdy_nxt   = 1'b0;
                    w_ok_nxt    = 1'b0;
                    w_i_nxt     = '0;
                    w_j_nxt     = '0;
                    w_k_nxt     = '0;
                    w_ph_nxt    = 1'b0;
                    w_clr       = 1'b1;
                end
            end
            RD_LEN: begin
                w_len_nxt       = ct_rddata;
                w_pt_addr_nxt   = '0;
                w_pt_wrdata_nxt = ct_rddata;
                w_pt_wren_nxt   = 1'b1;
                w_i_nxt         = w_i_inc;
                w_s_addr_nxt    = w_i_inc;
                w_state_nxt     = WR_PT;
            end
            RD_SI: begin
                w_si_nxt     = s_rddata;
                w_j_nxt      = r_j + s_rddata;
                w_s_addr_nxt = r_j + s_rddata;
                w_ph_nxt     = 1'b0;
                w_state_nxt  = RD_SJ;
            end
            RD_SJ: begin
                if (!r_ph) begin
                    w_ph_nxt = 1'b1;
                end else begin
                    w_sj_nxt       = s_rddata;
                    w_s_wren_nxt   = 1'b1;
                    w_s_addr_nxt   = r_i;
                    w_s_wrdata_nxt = s_rddata;
                    w_ph_nxt       = 1'b0;
                    w_state_nxt    = WR_SWAP;
                end
            end
            WR_SWAP: begin
                if (!r_ph) begin
                    w_s_wren_nxt   = 1'b1;
                    w_s_addr_nxt   = r_j;
                    w_s_wrdata_nxt = r_si;
                    w_ph_nxt       = 1'b1;
                end else begin
                    w_s_addr_nxt = r_si + r_sj;
                    w_ph_nxt     = 1'b0;
                    w_state_nxt  = RD_KS;
                end
            end
            RD_KS: begin
                if (!r_ph) begin
                    w_ph_nxt = 1'b1;
                end else begin
                    w_pt_wren_nxt   = 1'b1;
                    w_pt_addr_nxt   = CT_AW'(r_k);
                    w_pt_wrdata_nxt = ct_rddata ^ s_rddata;
                    w_i_nxt         = w_i_inc;
                    w_s_addr_nxt    = w_i_inc;
                    w_ph_nxt        = 1'b0;
                    w_state_nxt     = WR_PT;
                end
            end
            WR_PT: begin
                if ((r_k == r_len) || w_abort_c) begin
                    w_s_addr_nxt  = '0;
                    w_ct_addr_nxt = '0;
                    w_pt_addr_nxt = '0;
                    w_state_nxt   = DONE;
                end else begin
                    w_k_nxt       = r_k + BYTE_W'(1);
                    w_ct_addr_nxt = CT_AW'(r_k + BYTE_W'(1));
                    w_state_nxt   = RD_SI;
                end
            end
            DONE: begin
                w_rdy_nxt   = 1'b1;
                w_ok_nxt    = !w_fail;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ph        <= 1'b0;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_len       <= '0;
            r_si        <= '0;
            r_sj        <= '0;
            r_rdy       <= 1'b1;
            r_ok        <= 1'b0;
            r_s_addr    <= '0;
            r_s_wrdata  <= '0;
            r_s_wren    <= 1'b0;
            r_ct_addr   <= '0;
            r_pt_addr   <= '0;
            r_pt_wrdata <= '0;
            r_pt_wren   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ph        <= w_ph_nxt;
            r_i         <= w_i_nxt;
            r_j         <= w_j_nxt;
            r_k         <= w_k_nxt;
            r_len       <= w_len_nxt;
            r_si        <= w_si_nxt;
            r_sj        <= w_sj_nxt;
            r_rdy       <= w_rdy_nxt;
            r_ok        <= w_ok_nxt;
            r_s_addr    <= w_s_addr_nxt;
            r_s_wrdata  <= w_s_wrdata_nxt;
            r_s_wren    <= w_s_wren_nxt;
            r_ct_addr   <= w_ct_addr_nxt;
            r_pt_addr   <= w_pt_addr_nxt;
            r_pt_wrdata <= w_pt_wrdata_nxt;
            r_pt_wren   <= w_pt_wren_nxt;
        end
    end

    assign rdy       = r_rdy;
    assign ok        = r_ok;
    assign s_addr    = r_s_addr;
    assign s_wrdata  = r_s_wrdata;
    assign s_wren    = r_s_wren;
    assign ct_addr   = r_ct_addr;
    assign pt_addr   = r_pt_addr;
    assign pt_wrdata = r_pt_wrdata;
    assign pt_wren   = r_pt_wren;

endmodule

// File: tb/tb_prga_check.sv
// tb_prga_check: RAM models plus an RC4 reference; expected pt writes are queued per run
// and popped as the DUT writes them.
module tb_prga_check;

    localparam int unsigned CT_AW = 8;
    localparam int unsigned EW    = CT_AW + 8;

    logic             clk = 1'b0;
    logic             rst_n, en, ld;
    logic             rdy, ok;
    logic [7:0]       s_addr, s_rddata, s_wrdata;
    logic             s_wren;
    logic [CT_AW-1:0] ct_addr, pt_addr;
    logic [7:0]       ct_rddata, pt_wrdata;
    logic             pt_wren;

    prga_check #(
        .CT_AW  (CT_AW),
        .CHK_LO (8'h20),
        .CHK_HI (8'h7E)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .ok        (ok),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren)
    );

    always #5 clk = ~clk;

    logic [7:0]    s_mem [256];
    logic [7:0]    ct_mem[256];
    logic [7:0]    s_init[256];
    logic [7:0]    ct_init[256];
    logic [7:0]    msg[256];
    logic [7:0]    ms[256];
    logic [7:0]    ks[256];
    logic [EW-1:0] exp_q[$];
    int            n_chk = 0;
    int            n_err = 0;
    int            n_wr  = 0;

    // Synchronous-read RAMs, one cycle latency; ld bulk-loads S and ct while the DUT is idle.
    always @(posedge clk) begin
        if (ld) begin
            s_mem  <= s_init;
            ct_mem <= ct_init;
        end else if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
        end
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : pt_monitor
        logic [EW-1:0] e;
        if (rst_n && pt_wren) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("pt_wr_unexpected", 32'({pt_addr, pt_wrdata}), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("pt_wr", 32'({pt_addr, pt_wrdata}), 32'(e));
            end
        end
    end

    task automatic ksa(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
        logic [7:0] key[3];
        logic [7:0] j, t;
        key[0] = k0; key[1] = k1; key[2] = k2;
        j = 8'd0;
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        for (int x = 0; x < 256; x++) begin
            j = j + s_init[x] + key[x % 3];
            t = s_init[x]; s_init[x] = s_init[j]; s_init[j] = t;
        end
    endtask

    task automatic model_run(input int n);
        logic [7:0] i, j, t;
        i = 8'd0; j = 8'd0;
        for (int x = 0; x < 256; x++) ms[x] = s_init[x];
        for (int k = 1; k <= n; k++) begin
            i = i + 8'd1;
            j = j + ms[i];
            t = ms[i]; ms[i] = ms[j]; ms[j] = t;
            t = ms[i] + ms[j];
            ks[k] = ms[t];
        end
    endtask

    task automatic build_ct(input int len);
        model_run(len);
        for (int x = 0; x < 256; x++) ct_init[x] = 8'h00;
        ct_init[0] = 8'(len);
        for (int k = 1; k <= len; k++) ct_init[k] = msg[k] ^ ks[k];
    endtask

    task automatic load_mem();
        @(negedge clk); ld = 1'b1;
        @(negedge clk); ld = 1'b0;
    endtask

    task automatic rand_msg(input int len);
        for (int k = 1; k <= len; k++) msg[k] = 8'($urandom_range(32, 126));
    endtask

    task automatic prepare_expect(input int len, output logic exp_ok, output int n_steps);
        exp_ok  = 1'b1;
        n_steps = len;
        exp_q.push_back({CT_AW'(0), 8'(len)});
        for (int k = 1; k <= len; k++) begin
            exp_q.push_back({CT_AW'(k), msg[k]});
            if ((msg[k] < 8'h20) || (msg[k] > 8'h7E)) begin
                exp_ok = 1'b0;
`ifdef PRGA_EARLY_ABORT_EN
                n_steps = k;
                break;
`endif
            end
        end
    endtask

    task automatic check_s_final(input string tag, input int n_steps);
        int bad;
        bad = 0;
        model_run(n_steps);
        for (int x = 0; x < 256; x++) if (s_mem[x] !== ms[x]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    task automatic do_run(input string name, input int len, input int en_cycles);
        logic exp_ok;
        int   n_steps, n_exp, cyc, limit, wr0;
        prepare_expect(len, exp_ok, n_steps);
        n_exp = exp_q.size();
        limit = 9 * len + 6;
        wr0   = n_wr;
        @(negedge clk); en = 1'b1;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc >= en_cycles) en = 1'b0;
            if (cyc == 1) begin
                chk({name, "_rdy_drop"}, 32'(rdy), 32'd0);
                chk({name, "_ok_clr"}, 32'(ok), 32'd0);
            end
            if (rdy || (cyc > limit)) break;
        end
        en = 1'b0;
        chk({name, "_rdy_in_time"}, 32'(cyc <= limit), 32'd1);
        chk({name, "_ok"}, 32'(ok), 32'(exp_ok));
        repeat (3) @(negedge clk);
        chk({name, "_wr_cnt"}, 32'(n_wr - wr0), 32'(n_exp));
        chk({name, "_q_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_ok_hold"}, 32'(ok), 32'(exp_ok));
        check_s_final({name, "_s_final"}, n_steps);
        exp_q.delete();
    endtask

    initial begin : main
        string txt;
        int    len, wr0, n_st;
        logic  e_ok;
        rst_n = 1'b0; en = 1'b0; ld = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_ok", 32'(ok), 32'd0);
        chk("rst_s_wren", 32'(s_wren), 32'd0);
        chk("rst_pt_wren", 32'(pt_wren), 32'd0);
        chk("rst_s_addr", 32'(s_addr), 32'd0);
        chk("rst_ct_addr", 32'(ct_addr), 32'd0);
        chk("rst_pt_addr", 32'(pt_addr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Printable message under KSA(00 01 55)
        ksa(8'h00, 8'h01, 8'h55);
        txt = "PRGA test1: the quick brown fox!";
        len = txt.len();
        for (int k = 0; k < len; k++) msg[k + 1] = txt[k];
        build_ct(len); load_mem();
        do_run("test1", len, 1);

        // Zero-length message
        build_ct(0); load_mem();
        do_run("len0", 0, 1);

        // Non-printable byte at k=3
        rand_msg(10);
        msg[3] = 8'h07;
        build_ct(10); load_mem();
        do_run("range", 10, 1);

        // Reset during an L=50 run at cycle 20
        rand_msg(50);
        build_ct(50); load_mem();
        prepare_expect(50, e_ok, n_st);
        @(negedge clk); en = 1'b1;
        @(negedge clk); en = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_rdy", 32'(rdy), 32'd1);
        chk("midrst_ok", 32'(ok), 32'd0);
        chk("midrst_s_wren", 32'(s_wren), 32'd0);
        chk("midrst_pt_wren", 32'(pt_wren), 32'd0);
        chk("midrst_s_addr", 32'(s_addr), 32'd0);
        chk("midrst_ct_addr", 32'(ct_addr), 32'd0);
        chk("midrst_pt_addr", 32'(pt_addr), 32'd0);
        exp_q.delete();
        wr0 = n_wr;
        @(negedge clk); rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_wr", 32'(n_wr - wr0), 32'd0);
        chk("midrst_rdy_hold", 32'(rdy), 32'd1);
        load_mem();
        do_run("fresh", 50, 1);

        // en held high for 30 cycles over an L=8 run
        rand_msg(8);
        build_ct(8); load_mem();
        do_run("en_hold", 8, 30);

        // S[1]=255, S[2]=1, S[255]=2: j goes 255 then wraps to 0
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        s_init[1] = 8'd255; s_init[2] = 8'd1; s_init[255] = 8'd2;
        rand_msg(255);
        build_ct(255); load_mem();
        do_run("wrap255", 255, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
